// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller for ID-stage branch resolution in a 5-stage MIPS pipeline.
// Holds the front end until the ID-stage comparator operands are valid. It then
// redirects the PC and flushes IF/ID on a taken branch or jump. It also keeps
// saturating statistics of branches, taken branches and stall cycles.
module branch_hazard_ctrl #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Branch,
   input  logic             Taken,
   input  logic             UsesRs,
   input  logic             UsesRt,
   input  logic [REG_W-1:0] Rs,
   input  logic [REG_W-1:0] Rt,
   input  logic             IDEX_RegWrite,
   input  logic             IDEX_MemRead,
   input  logic [REG_W-1:0] IDEX_Dst,
   input  logic             EXMEM_RegWrite,
   input  logic             EXMEM_MemRead,
   input  logic [REG_W-1:0] EXMEM_Dst,
   input  logic             ClrStats,
   output logic             Stall,
   output logic             Bubble,
   output logic             PCSrc,
   output logic             Flush,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] TakenCount,
   output logic [CNT_W-1:0] StallCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, STALL} state_t;

   state_t     state;
   logic [1:0] cnt;
   logic       idex_dep;
   logic       exmem_dep;
   logic [1:0] need;
   logic       stall_int;
   logic       resolve;

   // A producer conflicts only when it targets a non-zero register the branch actually reads
   assign idex_dep  = (IDEX_Dst  != '0) && ((UsesRs && IDEX_Dst  == Rs) || (UsesRt && IDEX_Dst  == Rt));
   assign exmem_dep = (EXMEM_Dst != '0) && ((UsesRs && EXMEM_Dst == Rs) || (UsesRt && EXMEM_Dst == Rt));

   // Stall cycles needed before comparator operands are valid; EX/MEM ALU results are forwarded
   always_comb begin
      need = 2'd0;
      if (IDEX_MemRead && idex_dep)
         need = 2'd2;
      else if (IDEX_RegWrite && idex_dep)
         need = 2'd1;
      else if (EXMEM_MemRead && exmem_dep)
         need = 2'd1;
   end

   // Outputs are gated by Rst so they drop the moment reset asserts, even mid-stall
   assign stall_int = Rst && ((state == STALL) || (Branch && need != 2'd0));
   assign resolve   = Rst && (state == IDLE) && Branch && (need == 2'd0);
   assign Stall     = stall_int;
   assign Bubble    = stall_int;
   assign PCSrc     = resolve && Taken;
   assign Flush     = resolve && Taken;

   // Stall sequencer: a 2-cycle load-use stall is held in STALL, single stalls re-evaluate in IDLE
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (Branch && need != 2'd0) begin
                  cnt   <= need - 2'd1;
                  state <= (need == 2'd2) ? STALL : IDLE;
               end
            end
            STALL: begin
               cnt <= cnt - 2'd1;
               if (cnt == 2'd1)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= 2'd0;
            end
         endcase
      end
   end

   // Saturating statistics; a clear takes priority over any same-cycle increment
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         BranchCount <= '0;
         TakenCount  <= '0;
         StallCount  <= '0;
      end else if (ClrStats) begin
         BranchCount <= '0;
         TakenCount  <= '0;
         StallCount  <= '0;
      end else begin
         if (resolve && BranchCount != CNT_MAX)
            BranchCount <= BranchCount + CNT_ONE;
         if (resolve && Taken && TakenCount != CNT_MAX)
            TakenCount <= TakenCount + CNT_ONE;
         if (stall_int && StallCount != CNT_MAX)
            StallCount <= StallCount + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed pipeline scenarios, an abstract per-cycle
// model checked on every falling edge, and hand-computed literal expectations.
// A second instance with 3-bit counters exercises saturation cheaply.
module tb_branch_hazard_ctrl;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Branch = 0, Taken = 0, UsesRs = 0, UsesRt = 0;
   logic [4:0] Rs = 0, Rt = 0;
   logic       IDEX_RegWrite = 0, IDEX_MemRead = 0;
   logic [4:0] IDEX_Dst = 0;
   logic       EXMEM_RegWrite = 0, EXMEM_MemRead = 0;
   logic [4:0] EXMEM_Dst = 0;
   logic       ClrStats = 0;

   logic        Stall, Bubble, PCSrc, Flush;
   logic [15:0] BranchCount, TakenCount, StallCount;
   logic        Stall_s, Bubble_s, PCSrc_s, Flush_s;
   logic [2:0]  BranchCount_s, TakenCount_s, StallCount_s;

   int errs   = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   branch_hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
      .Clk(Clk), .Rst(Rst), .Branch(Branch), .Taken(Taken), .UsesRs(UsesRs), .UsesRt(UsesRt),
      .Rs(Rs), .Rt(Rt), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
      .IDEX_Dst(IDEX_Dst), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead),
      .EXMEM_Dst(EXMEM_Dst), .ClrStats(ClrStats), .Stall(Stall), .Bubble(Bubble),
      .PCSrc(PCSrc), .Flush(Flush), .BranchCount(BranchCount), .TakenCount(TakenCount),
      .StallCount(StallCount));

   branch_hazard_ctrl #(.CNT_W(3), .REG_W(5)) dut_s (
      .Clk(Clk), .Rst(Rst), .Branch(Branch), .Taken(Taken), .UsesRs(UsesRs), .UsesRt(UsesRt),
      .Rs(Rs), .Rt(Rt), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
      .IDEX_Dst(IDEX_Dst), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead),
      .EXMEM_Dst(EXMEM_Dst), .ClrStats(ClrStats), .Stall(Stall_s), .Bubble(Bubble_s),
      .PCSrc(PCSrc_s), .Flush(Flush_s), .BranchCount(BranchCount_s), .TakenCount(TakenCount_s),
      .StallCount(StallCount_s));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_left: forced stall cycles still owed after a load-use decision
   int     m_left = 0, n_left = 0;
   longint m_bc = 0, m_tc = 0, m_sc = 0;
   longint n_bc = 0, n_tc = 0, n_sc = 0;

   function automatic bit dep(input logic [4:0] d);
      return (d != 0) && ((UsesRs && d == Rs) || (UsesRt && d == Rt));
   endfunction

   function automatic int need_f();
      if (IDEX_MemRead && dep(IDEX_Dst)) return 2;
      if (IDEX_RegWrite && dep(IDEX_Dst)) return 1;
      if (EXMEM_MemRead && dep(EXMEM_Dst)) return 1;
      return 0;
   endfunction

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge Clk) begin
      logic e_stall, e_pc, res;
      int   nd;
      e_stall = 0; e_pc = 0; res = 0;
      if (!Rst) begin
         n_left = 0; n_bc = 0; n_tc = 0; n_sc = 0;
      end else begin
         n_left = 0;
         if (m_left > 0) begin
            e_stall = 1;
            n_left  = m_left - 1;
         end else if (Branch) begin
            nd = need_f();
            if (nd > 0) begin
               e_stall = 1;
               n_left  = nd - 1;
            end else begin
               res  = 1;
               e_pc = Taken;
            end
         end
         n_bc = m_bc + res;
         n_tc = m_tc + (res && Taken);
         n_sc = m_sc + e_stall;
         if (ClrStats) begin
            n_bc = 0; n_tc = 0; n_sc = 0;
         end
      end
      chk("m_stall",  32'(Stall),  32'(e_stall));
      chk("m_bubble", 32'(Bubble), 32'(e_stall));
      chk("m_pcsrc",  32'(PCSrc),  32'(e_pc));
      chk("m_flush",  32'(Flush),  32'(e_pc));
      chk("m_stall_s", 32'(Stall_s), 32'(e_stall));
      chk("m_pcsrc_s", 32'(PCSrc_s), 32'(e_pc));
      chk("m_bcnt",   32'(BranchCount), 32'(sat(m_bc, 16)));
      chk("m_tcnt",   32'(TakenCount),  32'(sat(m_tc, 16)));
      chk("m_scnt",   32'(StallCount),  32'(sat(m_sc, 16)));
      chk("m_bcnt_s", 32'(BranchCount_s), 32'(sat(m_bc, 3)));
      chk("m_tcnt_s", 32'(TakenCount_s),  32'(sat(m_tc, 3)));
      chk("m_scnt_s", 32'(StallCount_s),  32'(sat(m_sc, 3)));
   end

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         m_left <= 0; m_bc <= 0; m_tc <= 0; m_sc <= 0;
      end else begin
         m_left <= n_left; m_bc <= n_bc; m_tc <= n_tc; m_sc <= n_sc;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_id(input logic br, input logic tk, input logic urs, input logic urt,
                         input logic [4:0] rs, input logic [4:0] rt);
      Branch = br; Taken = tk; UsesRs = urs; UsesRt = urt; Rs = rs; Rt = rt;
   endtask

   task automatic set_idex(input logic w, input logic m, input logic [4:0] d);
      IDEX_RegWrite = w; IDEX_MemRead = m; IDEX_Dst = d;
   endtask

   task automatic set_exmem(input logic w, input logic m, input logic [4:0] d);
      EXMEM_RegWrite = w; EXMEM_MemRead = m; EXMEM_Dst = d;
   endtask

   task automatic clear_stats();
      set_id(0, 0, 0, 0, 0, 0);
      ClrStats = 1;
      tick();
      ClrStats = 0;
   endtask

   initial begin
      // Reset and initial state
      repeat (2) @(posedge Clk);
      #1 Rst = 1;
      #1;
      chk("rst_stall", 32'(Stall), 0);
      chk("rst_bcnt",  32'(BranchCount), 0);

      // beq $3,$4, no hazards, taken: resolves the same cycle
      set_id(1, 1, 1, 1, 5'd3, 5'd4);
      #1;
      chk("beq_pcsrc", 32'(PCSrc), 1);
      chk("beq_flush", 32'(Flush), 1);
      chk("beq_stall", 32'(Stall), 0);
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      chk("beq_bcnt", 32'(BranchCount), 1);
      chk("beq_tcnt", 32'(TakenCount), 1);
      tick();

      // lw $3 in ID/EX then beq $3,$4: two stall cycles, resolve in cycle 3
      clear_stats();
      set_idex(1, 1, 5'd3);
      set_id(1, 1, 1, 1, 5'd3, 5'd4);
      #1;
      chk("lu_c1_stall",  32'(Stall), 1);
      chk("lu_c1_bubble", 32'(Bubble), 1);
      chk("lu_c1_pcsrc",  32'(PCSrc), 0);
      tick();
      set_idex(0, 0, 0);
      set_exmem(1, 1, 5'd3);
      #1;
      chk("lu_c2_stall", 32'(Stall), 1);
      chk("lu_c2_pcsrc", 32'(PCSrc), 0);
      tick();
      set_exmem(0, 0, 0);
      #1;
      chk("lu_c3_stall", 32'(Stall), 0);
      chk("lu_c3_pcsrc", 32'(PCSrc), 1);
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      chk("lu_scnt", 32'(StallCount), 2);
      chk("lu_bcnt", 32'(BranchCount), 1);

      // add $5 in ID/EX then bgtz $5: one stall, then forwarded from EX/MEM
      clear_stats();
      set_idex(1, 0, 5'd5);
      set_id(1, 0, 1, 0, 5'd5, 5'd0);
      #1;
      chk("alu_c1_stall", 32'(Stall), 1);
      tick();
      set_idex(0, 0, 0);
      set_exmem(1, 0, 5'd5);
      #1;
      chk("alu_c2_stall", 32'(Stall), 0);
      chk("alu_c2_pcsrc", 32'(PCSrc), 0);
      tick();
      set_exmem(0, 0, 0);
      set_id(0, 0, 0, 0, 0, 0);
      chk("alu_scnt", 32'(StallCount), 1);
      chk("alu_tcnt", 32'(TakenCount), 0);
      // $0 destination never creates a dependence
      set_idex(1, 0, 5'd0);
      set_id(1, 1, 1, 0, 5'd0, 5'd0);
      #1;
      chk("r0_stall", 32'(Stall), 0);
      chk("r0_pcsrc", 32'(PCSrc), 1);
      tick();
      set_idex(0, 0, 0);

      // bltz with only the unused rt field matching: no stall
      set_idex(1, 1, 5'd6);
      set_id(1, 0, 1, 0, 5'd7, 5'd6);
      #1;
      chk("rt_unused_stall", 32'(Stall), 0);
      tick();
      set_idex(0, 0, 0);
      // bltz $6 with lw $6 in EX/MEM: one stall
      set_exmem(1, 1, 5'd6);
      set_id(1, 1, 1, 0, 5'd6, 5'd0);
      #1;
      chk("exld_stall", 32'(Stall), 1);
      tick();
      set_exmem(0, 0, 0);
      #1;
      chk("exld_pcsrc", 32'(PCSrc), 1);
      tick();
      set_id(0, 0, 0, 0, 0, 0);

      // Reset asserted mid-STALL (Cnt=1): outputs drop at once, counters clear
      set_idex(1, 1, 5'd3);
      set_id(1, 0, 1, 1, 5'd3, 5'd4);
      tick();
      set_idex(0, 0, 0);
      #1;
      chk("mid_stall_pre", 32'(Stall), 1);
      Rst = 0;
      #1;
      chk("mid_rst_stall",  32'(Stall), 0);
      chk("mid_rst_bubble", 32'(Bubble), 0);
      chk("mid_rst_scnt",   32'(StallCount), 0);
      chk("mid_rst_bcnt",   32'(BranchCount), 0);
      tick();
      Rst = 1;
      set_id(1, 1, 1, 1, 5'd3, 5'd4);
      #1;
      chk("post_rst_idle_pc", 32'(PCSrc), 1);
      chk("post_rst_idle_st", 32'(Stall), 0);
      tick();

      // Saturation on the narrow instance: 10 taken branches, then 10 stall cycles
      clear_stats();
      set_id(1, 1, 1, 1, 5'd3, 5'd4);
      repeat (10) tick();
      chk("sat_bcnt_s", 32'(BranchCount_s), 7);
      chk("sat_tcnt_s", 32'(TakenCount_s), 7);
      chk("sat_bcnt",   32'(BranchCount), 10);
      set_idex(1, 1, 5'd3);
      repeat (10) tick();
      chk("sat_scnt_s", 32'(StallCount_s), 7);
      chk("sat_scnt",   32'(StallCount), 10);
      chk("sat_bcnt_s_hold", 32'(BranchCount_s), 7);
      set_idex(0, 0, 0);
      // Drain any pending load-use stall before the clear
      set_id(0, 0, 0, 0, 0, 0);
      repeat (2) tick();

      // Clear wins over a same-cycle taken branch
      set_id(1, 1, 1, 1, 5'd3, 5'd4);
      ClrStats = 1;
      tick();
      ClrStats = 0;
      set_id(0, 0, 0, 0, 0, 0);
      chk("clr_bcnt",   32'(BranchCount), 0);
      chk("clr_tcnt",   32'(TakenCount), 0);
      chk("clr_scnt",   32'(StallCount), 0);
      chk("clr_bcnt_s", 32'(BranchCount_s), 0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
